alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-port sequencer that shares one combinational 64-bit `alu` instance between two requesters, such as the integer pipe and the address-generation unit. It performs round-robin arbitration and registers the winner's opcode and operands onto the ALU inputs. It holds them for a programmable settle time, covering the carry-propagation depth of the Kogge-Stone adder, then captures result and flag and returns them to the winner over a valid/ready handshake.

## Interface
- `WIDTH`, 64, datapath width; must match the `alu` instance.
- `EXEC_CYCLES`, 1, cycles the ALU inputs are held before capture; legal range 1..15.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-high; clears all state.
- `req0_valid` / `req1_valid`  in  1  request present.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle (combinational).
- `req0_op` / `req1_op`  in  2  opcode: 00 add, 01 sub, 10 and, 11 xor.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  WIDTH  operands.
- `rsp0_valid` / `rsp1_valid`  out  1  response for that requester.
- `rsp0_ready` / `rsp1_ready`  in  1  requester takes the response.
- `rsp_result`  out  WIDTH  shared response data.
- `rsp_flag`  out  1  shared response flag.
- `alu_op`  out  2  registered opcode to the ALU.
- `alu_a`, `alu_b`  out  WIDTH  registered operands to the ALU.
- `alu_out`  in  WIDTH  ALU result.
- `alu_flag`  in  1  ALU flag: carry for add, borrow for sub, 0 for and/xor.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM has three states: IDLE, EXEC, RESP. Reset state is IDLE.
- **Round-robin pointer.** `last_grant` resets to 1, so requester 0 wins the first contest.
- **IDLE arbitration.**
  - Winner is the single valid requester.
  - If both are valid, the winner is the one not equal to `last_grant`.
  - Only the winner's `reqN_ready` is high.
  - No ready is asserted in EXEC or RESP.
- **Accept** (valid & ready at an edge in IDLE):
  - latch op, a and b into `alu_op`, `alu_a`, `alu_b`;
  - set `gnt_id` and `last_grant` to the winner;
  - load the counter with EXEC_CYCLES-1;
  - go to EXEC.
- **EXEC.**
  - If the counter is nonzero, decrement it.
  - If the counter is 0, capture `alu_out` into `rsp_result` and `alu_flag` into `rsp_flag`, assert `rsp{gnt_id}_valid`, and go to RESP.
- **RESP.**
  - Hold response, `gnt_id` and the ALU input registers stable.
  - On `rsp{gnt_id}_ready`, deassert valid and go to IDLE.
  - The non-granted requester's `rsp_ready` is ignored.
- **ALU input registers** keep their last value in IDLE. They are not cleared after use.
- **Arithmetic.** Results wrap modulo 2^WIDTH. The flag is passed through unmodified; there is no saturation or sign handling.
- **Requester rules.** Requesters hold valid, op and operands stable until accepted. Dropping valid before acceptance is allowed and simply withdraws the request.
- **Reset mid-operation** (EXEC or RESP) discards the in-flight op. The response is never delivered.
- **Reset values:** `req*_ready`=0, `rsp*_valid`=0, `rsp_result`=0, `rsp_flag`=0, `alu_op`=0, `alu_a`=0, `alu_b`=0, `busy`=0.

## Timing
- Accept at edge T. ALU inputs are valid after T.
- Capture at edge T+EXEC_CYCLES. `rspN_valid` is high from T+EXEC_CYCLES.
- With `rsp_ready` tied high, the response handshake occurs at T+EXEC_CYCLES+1. The FSM is in IDLE after that edge.
- Next accept is possible at edge T+EXEC_CYCLES+2 at the earliest.
- Throughput is one op per EXEC_CYCLES+2 cycles. There is no pipelining and no accept in the same cycle as a response handshake.
- `req*_ready` depends combinationally on state, both `req*_valid` and `last_grant`. It does not depend on `rsp*_ready`.
- `busy` equals (state != IDLE) and is registered via the state.

## Test plan
- **Reset defaults:** assert `rst` asynchronously mid-cycle -> all outputs 0 immediately; first contest with both valid grants requester 0.
- **Single add, EXEC_CYCLES=1, `rsp0_ready`=1:** req0 add a=0xFFFFFFFFFFFFFFFF, b=1 -> `rsp0_valid` one cycle after accept with `rsp_result`=0, `rsp_flag`=1; `req0_ready` high again 3 cycles after the first accept.
- **Round-robin:** both requesters valid continuously, req0 xor 0xF0F0/0x0FF0, req1 sub 5-7 -> grants alternate 0,1,0,1. Results are 0xFF00 (flag 0) and 0xFFFFFFFFFFFFFFFE with flag per the ALU borrow convention.
- **Response backpressure:** `rsp1_ready` held low 10 cycles -> `rsp1_valid`, `rsp_result` and `rsp_flag` are stable throughout; `req0_ready` stays 0 while req0 is valid; `rsp0_ready` toggling has no effect.
- **EXEC_CYCLES=4:** and 0x00FF00FF00FF00FF & 0x0F0F0F0F0F0F0F0F -> capture exactly 4 edges after accept with result 0x000F000F000F000F and flag 0; `busy` is high for 5 cycles with `rsp_ready`=1.
- **Reset during EXEC and during RESP:** `rst` pulse -> no `rsp*_valid` ever seen for the aborted op; the next request completes normally with correct data.

Source files
------------

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sequencer sharing one external ALU between two requesters
//
// Purpose: arbitrates two requesters, registers the winner's op/operands onto
// the ALU inputs, waits EXEC_CYCLES for the adder to settle, captures the
// result and flag, and returns them over a valid/ready handshake.
//
// Ports:
//   clk_i, rst_i                     clock, asynchronous active-high reset
//   reqN_valid_i / reqN_ready_o      request handshake (ready is combinational)
//   reqN_op_i, reqN_a_i, reqN_b_i    opcode (00 add, 01 sub, 10 and, 11 xor), operands
//   rspN_valid_o / rspN_ready_i      response handshake for requester N
//   rsp_result_o, rsp_flag_o         shared response data and flag
//   alu_op_o, alu_a_o, alu_b_o       registered ALU inputs
//   alu_out_i, alu_flag_i            ALU result and carry/borrow flag
//   busy_o                           high whenever the FSM is not idle
module alu_arbiter #(
  parameter int WIDTH       = 64,
  parameter int EXEC_CYCLES = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [1:0]       req0_op_i,
  input  logic [WIDTH-1:0] req0_a_i,
  input  logic [WIDTH-1:0] req0_b_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [1:0]       req1_op_i,
  input  logic [WIDTH-1:0] req1_a_i,
  input  logic [WIDTH-1:0] req1_b_i,
  output logic             rsp0_valid_o,
  input  logic             rsp0_ready_i,
  output logic             rsp1_valid_o,
  input  logic             rsp1_ready_i,
  output logic [WIDTH-1:0] rsp_result_o,
  output logic             rsp_flag_o,
  output logic [1:0]       alu_op_o,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  input  logic [WIDTH-1:0] alu_out_i,
  input  logic             alu_flag_i,
  output logic             busy_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Out-of-range settings are clamped so the 4-bit counter never wraps.
  localparam int         EXEC_CLAMP = (EXEC_CYCLES < 1)  ? 1  :
                                      (EXEC_CYCLES > 15) ? 15 : EXEC_CYCLES;
  localparam logic [3:0] CNT_LOAD   = 4'(EXEC_CLAMP - 1);

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             last_grant_q, last_grant_d;
  logic             gnt_id_q, gnt_id_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             flag_q, flag_d;

  logic is_idle;
  logic grant0;
  logic grant1;
  logic rsp_hs;

  assign is_idle = (state_q == ST_IDLE);

  // On contention the requester that did not win last time goes first.
  assign grant0 = is_idle & req0_valid_i & (~req1_valid_i | last_grant_q);
  assign grant1 = is_idle & req1_valid_i & (~req0_valid_i | ~last_grant_q);

  // Only the granted requester's ready completes a response.
  assign rsp_hs = (state_q == ST_RESP) & (gnt_id_q ? rsp1_ready_i : rsp0_ready_i);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    gnt_id_d     = gnt_id_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    result_d     = result_q;
    flag_d       = flag_q;

    case (state_q)
      ST_IDLE: begin
        if (grant0 || grant1) begin
          alu_op_d     = grant1 ? req1_op_i : req0_op_i;
          alu_a_d      = grant1 ? req1_a_i  : req0_a_i;
          alu_b_d      = grant1 ? req1_b_i  : req0_b_i;
          gnt_id_d     = grant1;
          last_grant_d = grant1;
          cnt_d        = CNT_LOAD;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          result_d = alu_out_i;
          flag_d   = alu_flag_i;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_hs) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b1;
      gnt_id_q     <= 1'b0;
      alu_op_q     <= 2'd0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      result_q     <= '0;
      flag_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      gnt_id_q     <= gnt_id_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      result_q     <= result_d;
      flag_q       <= flag_d;
    end
  end

  assign req0_ready_o = grant0;
  assign req1_ready_o = grant1;
  assign rsp0_valid_o = (state_q == ST_RESP) & ~gnt_id_q;
  assign rsp1_valid_o = (state_q == ST_RESP) &  gnt_id_q;
  assign rsp_result_o = result_q;
  assign rsp_flag_o   = flag_q;
  assign alu_op_o     = alu_op_q;
  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign busy_o       = ~is_idle;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;

  typedef struct {
    logic        id;
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic        flag;
  } vec_t;

  int total = 0;
  int bad   = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [1:0]  req0_op = 2'd0, req1_op = 2'd0;
  logic [63:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [63:0] rsp_result;
  logic        rsp_flag;
  logic [1:0]  alu_op;
  logic [63:0] alu_a, alu_b, alu_out;
  logic        alu_flag;
  logic        busy;

  logic        x_req0_valid = 1'b0, x_req1_valid = 1'b0;
  logic        x_req0_ready, x_req1_ready;
  logic        x_rsp0_valid, x_rsp1_valid;
  logic        x_rsp0_ready = 1'b1, x_rsp1_ready = 1'b1;
  logic [63:0] x_rsp_result;
  logic        x_rsp_flag;
  logic [1:0]  x_alu_op;
  logic [63:0] x_alu_a, x_alu_b, x_alu_out;
  logic        x_alu_flag;
  logic        x_busy;

  function automatic logic [64:0] alu_model(input logic [1:0] op, input logic [63:0] a,
                                            input logic [63:0] b);
    case (op)
      2'b00:   return {1'b0, a} + {1'b0, b};
      2'b01:   return {1'b0, a} - {1'b0, b};
      2'b10:   return {1'b0, a & b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  assign {alu_flag, alu_out}     = alu_model(alu_op, alu_a, alu_b);
  assign {x_alu_flag, x_alu_out} = alu_model(x_alu_op, x_alu_a, x_alu_b);

  alu_arbiter #(.WIDTH(64), .EXEC_CYCLES(1)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_op_i(req0_op),
    .req0_a_i(req0_a), .req0_b_i(req0_b),
    .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_op_i(req1_op),
    .req1_a_i(req1_a), .req1_b_i(req1_b),
    .rsp0_valid_o(rsp0_valid), .rsp0_ready_i(rsp0_ready),
    .rsp1_valid_o(rsp1_valid), .rsp1_ready_i(rsp1_ready),
    .rsp_result_o(rsp_result), .rsp_flag_o(rsp_flag),
    .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b),
    .alu_out_i(alu_out), .alu_flag_i(alu_flag), .busy_o(busy)
  );

  alu_arbiter #(.WIDTH(64), .EXEC_CYCLES(4)) dut4 (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(x_req0_valid), .req0_ready_o(x_req0_ready), .req0_op_i(req0_op),
    .req0_a_i(req0_a), .req0_b_i(req0_b),
    .req1_valid_i(x_req1_valid), .req1_ready_o(x_req1_ready), .req1_op_i(req1_op),
    .req1_a_i(req1_a), .req1_b_i(req1_b),
    .rsp0_valid_o(x_rsp0_valid), .rsp0_ready_i(x_rsp0_ready),
    .rsp1_valid_o(x_rsp1_valid), .rsp1_ready_i(x_rsp1_ready),
    .rsp_result_o(x_rsp_result), .rsp_flag_o(x_rsp_flag),
    .alu_op_o(x_alu_op), .alu_a_o(x_alu_a), .alu_b_o(x_alu_b),
    .alu_out_i(x_alu_out), .alu_flag_i(x_alu_flag), .busy_o(x_busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_dut1_zero(input string tag);
    chk({tag, "_req0_ready"}, req0_ready, 0);
    chk({tag, "_req1_ready"}, req1_ready, 0);
    chk({tag, "_rsp0_valid"}, rsp0_valid, 0);
    chk({tag, "_rsp1_valid"}, rsp1_valid, 0);
    chk({tag, "_result"}, rsp_result, 0);
    chk({tag, "_flag"}, rsp_flag, 0);
    chk({tag, "_alu_op"}, alu_op, 0);
    chk({tag, "_alu_a"}, alu_a, 0);
    chk({tag, "_alu_b"}, alu_b, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // One complete transaction on the EXEC_CYCLES=1 instance.
  task automatic run_vec(input vec_t v, input int idx);
    int n;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    if (v.id) begin
      req1_op = v.op; req1_a = v.a; req1_b = v.b; req1_valid = 1'b1;
    end else begin
      req0_op = v.op; req0_a = v.a; req0_b = v.b; req0_valid = 1'b1;
    end
    #1;
    n = 0;
    while (!(v.id ? req1_ready : req0_ready) && n < 20) begin tick(); n++; end
    chk($sformatf("vec%0d_ready", idx), v.id ? req1_ready : req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    n = 0;
    while (!(v.id ? rsp1_valid : rsp0_valid) && n < 20) begin tick(); n++; end
    chk($sformatf("vec%0d_latency", idx), 64'(n), 1);
    chk($sformatf("vec%0d_result", idx), rsp_result, v.res);
    chk($sformatf("vec%0d_flag", idx), rsp_flag, v.flag);
    chk($sformatf("vec%0d_other_valid", idx), v.id ? rsp0_valid : rsp1_valid, 0);
    tick();
    chk($sformatf("vec%0d_valid_drop", idx), v.id ? rsp1_valid : rsp0_valid, 0);
  endtask

  // One transaction on the EXEC_CYCLES=4 instance, checking capture latency and busy length.
  task automatic run_x(input string tag, input logic [1:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] res, input logic flag);
    int n;
    int lat;
    int busy_n;
    req0_op = op; req0_a = a; req0_b = b; x_req0_valid = 1'b1;
    #1;
    n = 0;
    while (!x_req0_ready && n < 20) begin tick(); n++; end
    chk({tag, "_ready"}, x_req0_ready, 1);
    tick();
    x_req0_valid = 1'b0;
    lat = -1;
    busy_n = 0;
    for (int k = 0; k < 12; k++) begin
      if (x_busy) busy_n++;
      if (x_rsp0_valid && lat < 0) begin
        lat = k;
        chk({tag, "_result"}, x_rsp_result, res);
        chk({tag, "_flag"}, x_rsp_flag, flag);
      end
      tick();
    end
    chk({tag, "_latency"}, 64'(lat), 4);
    chk({tag, "_busy_cycles"}, 64'(busy_n), 5);
  endtask

  task automatic reset_pulse();
    tick();
    #2 rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  vec_t vecs[8];

  initial begin
    int g;
    int k;
    int seen;
    logic grants[4];

    vecs[0] = '{1'b0, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1'b1};
    vecs[1] = '{1'b1, 2'b01, 64'h5, 64'h7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1};
    vecs[2] = '{1'b0, 2'b11, 64'hF0F0, 64'h0FF0, 64'hFF00, 1'b0};
    vecs[3] = '{1'b1, 2'b10, 64'h00FF_00FF_00FF_00FF, 64'h0F0F_0F0F_0F0F_0F0F,
                64'h000F_000F_000F_000F, 1'b0};
    vecs[4] = '{1'b0, 2'b01, 64'h7, 64'h5, 64'h2, 1'b0};
    vecs[5] = '{1'b1, 2'b00, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0, 1'b1};
    vecs[6] = '{1'b0, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF,
                64'hFEDC_BA98_7654_3210, 1'b0};
    vecs[7] = '{1'b1, 2'b01, 64'h0, 64'h0, 64'h0, 1'b0};

    // Reset asserted before any clock edge: outputs must clear asynchronously.
    #2 rst = 1'b1;
    #1;
    chk_dut1_zero("rst_init");
    chk("rst_init_x_busy", x_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("first_contest_r0", req0_ready, 1);
    chk("first_contest_r1", req1_ready, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;

    // Back-to-back add on requester 0: next accept three edges after the first.
    req0_op = 2'b00; req0_a = 64'hFFFF_FFFF_FFFF_FFFF; req0_b = 64'h1;
    req0_valid = 1'b1; rsp0_ready = 1'b1;
    #1;
    g = 0;
    while (!req0_ready && g < 20) begin tick(); g++; end
    chk("tput_first_ready", req0_ready, 1);
    tick();
    k = 0;
    do begin
      tick();
      k++;
      if (k == 1) begin
        chk("tput_rsp_valid", rsp0_valid, 1);
        chk("tput_result", rsp_result, 64'h0);
        chk("tput_flag", rsp_flag, 1);
      end
    end while (!req0_ready && k < 10);
    chk("tput_reaccept_edges", 64'(k + 1), 3);
    req0_valid = 1'b0;
    #1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Round-robin with both requesters continuously valid.
    reset_pulse();
    req0_op = 2'b11; req0_a = 64'hF0F0; req0_b = 64'h0FF0;
    req1_op = 2'b01; req1_a = 64'h5;    req1_b = 64'h7;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    g = 0;
    for (int i = 0; i < 40 && g < 4; i++) begin
      chk("rr_exclusive_ready", req0_ready & req1_ready, 0);
      if (req0_ready) begin grants[g] = 1'b0; g++; end
      else if (req1_ready) begin grants[g] = 1'b1; g++; end
      if (rsp0_valid) begin
        chk("rr_rsp0_result", rsp_result, 64'hFF00);
        chk("rr_rsp0_flag", rsp_flag, 0);
      end
      if (rsp1_valid) begin
        chk("rr_rsp1_result", rsp_result, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("rr_rsp1_flag", rsp_flag, 1);
      end
      if (g < 4) tick();
    end
    chk("rr_grant_count", 64'(g), 4);
    if (g == 4) begin
      chk("rr_grant0", grants[0], 0);
      chk("rr_grant1", grants[1], 1);
      chk("rr_grant2", grants[2], 0);
      chk("rr_grant3", grants[3], 1);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();

    // Response backpressure on requester 1.
    rsp1_ready = 1'b0;
    req1_valid = 1'b1;
    #1;
    g = 0;
    while (!req1_ready && g < 20) begin tick(); g++; end
    chk("bp_accept", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1;
    g = 0;
    while (!rsp1_valid && g < 20) begin tick(); g++; end
    for (int i = 0; i < 10; i++) begin
      chk("bp_rsp1_valid", rsp1_valid, 1);
      chk("bp_result", rsp_result, 64'hFFFF_FFFF_FFFF_FFFE);
      chk("bp_flag", rsp_flag, 1);
      chk("bp_req0_ready", req0_ready, 0);
      chk("bp_rsp0_valid", rsp0_valid, 0);
      rsp0_ready = ~rsp0_ready;
      tick();
    end
    rsp1_ready = 1'b1;
    tick();
    chk("bp_released_valid", rsp1_valid, 0);
    chk("bp_req0_ready_after", req0_ready, 1);
    req0_valid = 1'b0;
    rsp0_ready = 1'b1;
    tick();

    // Four-cycle settle instance.
    run_x("x_and", 2'b10, 64'h00FF_00FF_00FF_00FF, 64'h0F0F_0F0F_0F0F_0F0F,
          64'h000F_000F_000F_000F, 1'b0);

    // Reset while the slow instance is in EXEC.
    req0_op = 2'b00; req0_a = 64'h1; req0_b = 64'h2; x_req0_valid = 1'b1;
    #1;
    g = 0;
    while (!x_req0_ready && g < 20) begin tick(); g++; end
    chk("xabort_accept", x_req0_ready, 1);
    tick();
    x_req0_valid = 1'b0;
    tick();
    chk("xabort_in_exec", x_busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("xabort_busy", x_busy, 0);
    chk("xabort_alu_a", x_alu_a, 0);
    chk("xabort_result", x_rsp_result, 0);
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (x_rsp0_valid || x_rsp1_valid) seen++;
    end
    chk("xabort_no_rsp", 64'(seen), 0);
    run_x("x_after_abort", 2'b00, 64'h1, 64'h2, 64'h3, 1'b0);

    // Reset while the fast instance is holding a response.
    req1_op = 2'b01; req1_a = 64'h5; req1_b = 64'h7;
    rsp1_ready = 1'b0;
    req1_valid = 1'b1;
    #1;
    g = 0;
    while (!req1_ready && g < 20) begin tick(); g++; end
    tick();
    req1_valid = 1'b0;
    tick();
    chk("rabort_in_resp", rsp1_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk_dut1_zero("rabort");
    tick();
    rst = 1'b0;
    rsp1_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rsp0_valid || rsp1_valid) seen++;
    end
    chk("rabort_no_rsp", 64'(seen), 0);
    run_vec(vecs[1], 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
